bist_pe_scheduler: RTL
======================

BIST_PE_SCHEDULER -- requirements
Module: bist_pe_scheduler

Interface
REQ-001 Parameter ROWS, default 2: systolic array rows.
REQ-002 Parameter COLS, default 2: systolic array columns.
REQ-003 Parameter WORD_SIZE, default 16: PE/RMAC output word width.
REQ-004 Parameter SETTLE_CYCLES, default 4, legal range 1..255: cycles the RMAC runs before its output is compared.
REQ-005 Port clk, input, 1: single clock, rising edge.
REQ-006 Port rst, input, 1: asynchronous, active-high reset.
REQ-007 Port start, input, 1: begin a test sweep; sampled only in IDLE.
REQ-008 Port abort, input, 1: terminate the sweep and return to IDLE.
REQ-009 Port pe_sel_row, output, $clog2(ROWS) (min 1): row of the PE routed to the RMAC.
REQ-010 Port pe_sel_col, output, $clog2(COLS) (min 1): column of the PE routed to the RMAC.
REQ-011 Port rmac_en, output, 1: RMAC shadowing enabled.
REQ-012 Port pe_out, input, WORD_SIZE: output word of the selected PE.
REQ-013 Port rmac_out, input, WORD_SIZE: output word of the redundant MAC.
REQ-014 Port busy, output, 1: sweep in progress.
REQ-015 Port done, output, 1: one-cycle pulse at normal sweep completion.
REQ-016 Port fault_map, output, ROWS*COLS: bit r*COLS+c set means PE(r,c) mismatched.
REQ-017 Port fault_cnt, output, $clog2(ROWS*COLS+1): number of set fault_map bits.
REQ-018 Port any_fault, output, 1: OR-reduction of fault_map.

Function
REQ-019 The FSM SHALL have states IDLE, SELECT, SETTLE, COMPARE, ADVANCE and DONE.
REQ-020 IDLE with start=1 SHALL clear fault_map and fault_cnt, zero the row and column indices, and go to SELECT.
REQ-021 SELECT SHALL last one cycle, with rmac_en=1 and the selection held stable, then go to SETTLE.
REQ-022 SETTLE SHALL last exactly SETTLE_CYCLES cycles, counted by the settle timer, with rmac_en=1, then go to COMPARE.
REQ-023 COMPARE SHALL last one cycle; if pe_out != rmac_out it SHALL set fault_map[idx] and increment fault_cnt, then go to ADVANCE.
REQ-024 ADVANCE SHALL go to DONE when row==ROWS-1 and col==COLS-1.
REQ-025 Otherwise ADVANCE SHALL increment col, or set col=0 and increment row when col==COLS-1, then go to SELECT.
REQ-026 DONE SHALL assert done for one cycle, then go to IDLE.
REQ-027 Per-PE cost SHALL be SETTLE_CYCLES+3 cycles; done SHALL be high in cycle k+1+ROWS*COLS*(SETTLE_CYCLES+3), where k is the edge that samples start.
REQ-028 busy SHALL be 1 in every state except IDLE.
REQ-029 rmac_en SHALL be 1 only in SELECT and SETTLE.
REQ-030 start while busy SHALL be ignored.
REQ-031 abort SHALL take priority over all transitions; in any non-IDLE state it SHALL go to IDLE next cycle with no done pulse, retaining fault_map and fault_cnt.
REQ-032 abort and start high together in IDLE SHALL leave the FSM in IDLE.
REQ-033 fault_map, fault_cnt and any_fault SHALL hold their values from DONE until the next accepted start.
REQ-034 pe_sel_row and pe_sel_col SHALL stay at the last tested PE while in IDLE.
REQ-035 fault_cnt SHALL never wrap; its width covers ROWS*COLS.

Reset
REQ-036 rst SHALL asynchronously force: state IDLE; pe_sel_row, pe_sel_col, rmac_en, busy, done, fault_map, fault_cnt and any_fault all 0; settle timer cleared.
REQ-037 rst asserted mid-sweep SHALL abandon the sweep; the first start after release SHALL begin at PE(0,0).

Structure
REQ-038 The state enum and the default ROWS, COLS, WORD_SIZE and SETTLE_CYCLES SHALL be defined in the shared package bist_pkg.
REQ-039 The settle countdown SHALL be the sub-module bist_settle_timer, with inputs load and count value and output expired.
REQ-040 The pe_out and rmac_out routing mux SHALL be outside this block.

Verification (ROWS=COLS=2, SETTLE_CYCLES=4)
REQ-041 start pulse with pe_out==rmac_out throughout -> done in cycle k+29, fault_map=4'b0000, fault_cnt=0, any_fault=0.
REQ-042 rmac_out=pe_out^16'h0001 only while sel=(1,0) -> fault_map=4'b0100, fault_cnt=1, any_fault=1.
REQ-043 Mismatch on all PEs -> fault_map=4'b1111, fault_cnt=4, no wrap; a second start clears both to 0 in the following cycle.
REQ-044 abort in SETTLE of PE(0,1) after a fault on PE(0,0) -> IDLE next cycle, no done pulse, fault_map=4'b0001 retained.
REQ-045 start re-pulsed while busy, then rst asserted mid-sweep -> sweep unaffected by the start; rst drives all outputs to 0 asynchronously; the next sweep starts at sel=(0,0).

Source files
------------

// File: rtl/bist_pkg.sv
// Shared definitions for the PE built-in self-test scheduler: FSM encoding,
// default array geometry and a helper for index widths.
package bist_pkg;

   localparam int DEF_ROWS          = 2;
   localparam int DEF_COLS          = 2;
   localparam int DEF_WORD_SIZE     = 16;
   localparam int DEF_SETTLE_CYCLES = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SELECT,
      ST_SETTLE,
      ST_COMPARE,
      ST_ADVANCE,
      ST_DONE
   } bist_state_t;

   // Index width for a dimension of n entries, never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bist_settle_timer.sv
// Settle countdown: loaded while a PE is selected, expired flags the last
// cycle of the settle window so the FSM leaves SETTLE on the following edge.
module bist_settle_timer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic             expired
);

   logic [WIDTH-1:0] cnt_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt_reg <= '0;
      else if (load)
         cnt_reg <= load_value;
      else if (cnt_reg != '0)
         cnt_reg <= cnt_reg - WIDTH'(1);
   end

   assign expired = (cnt_reg == WIDTH'(1));

endmodule

// File: rtl/bist_pe_scheduler.sv
// Walks every PE of the systolic array, shadows it with the redundant MAC,
// and records PEs whose output disagrees with the RMAC after settling.
module bist_pe_scheduler
   import bist_pkg::*;
#(
   parameter int ROWS          = DEF_ROWS,
   parameter int COLS          = DEF_COLS,
   parameter int WORD_SIZE     = DEF_WORD_SIZE,
   parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
   localparam int ROW_W        = idx_width(ROWS),
   localparam int COL_W        = idx_width(COLS),
   localparam int NUM_PE       = ROWS * COLS,
   localparam int CNT_W        = $clog2(NUM_PE + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 abort,
   output logic [ROW_W-1:0]     pe_sel_row,
   output logic [COL_W-1:0]     pe_sel_col,
   output logic                 rmac_en,
   input  logic [WORD_SIZE-1:0] pe_out,
   input  logic [WORD_SIZE-1:0] rmac_out,
   output logic                 busy,
   output logic                 done,
   output logic [NUM_PE-1:0]    fault_map,
   output logic [CNT_W-1:0]     fault_cnt,
   output logic                 any_fault
);

   bist_state_t          state_reg, state_next;
   logic [ROW_W-1:0]     row_reg;
   logic [COL_W-1:0]     col_reg;
   logic [NUM_PE-1:0]    fault_map_reg;
   logic [CNT_W-1:0]     fault_cnt_reg;
   logic [NUM_PE-1:0]    sel_hit;
   logic                 settle_expired;
   logic                 start_accept;
   logic                 last_pe;
   logic                 mismatch;

   bist_settle_timer #(
      .WIDTH(8)
   ) u_settle_timer (
      .clk        (clk),
      .rst        (rst),
      .load       (state_reg == ST_SELECT),
      .load_value (8'(SETTLE_CYCLES)),
      .expired    (settle_expired)
   );

   // One-hot decode of the selected PE onto the fault_map bit layout.
   generate
      for (genvar gi = 0; gi < NUM_PE; gi++) begin : g_hit
         assign sel_hit[gi] = (row_reg == ROW_W'(gi / COLS)) &&
                              (col_reg == COL_W'(gi % COLS));
      end
   endgenerate

   assign start_accept = (state_reg == ST_IDLE) && start && !abort;
   assign last_pe      = (row_reg == ROW_W'(ROWS - 1)) && (col_reg == COL_W'(COLS - 1));
   assign mismatch     = (pe_out != rmac_out);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state_reg <= ST_IDLE;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:    if (start) state_next = ST_SELECT;
         ST_SELECT:  state_next = ST_SETTLE;
         ST_SETTLE:  if (settle_expired) state_next = ST_COMPARE;
         ST_COMPARE: state_next = ST_ADVANCE;
         ST_ADVANCE: state_next = last_pe ? ST_DONE : ST_SELECT;
         ST_DONE:    state_next = ST_IDLE;
         default:    state_next = ST_IDLE;
      endcase
      // Abort overrides everything, including a start seen in IDLE.
      if (abort)
         state_next = ST_IDLE;
   end

   always_comb begin
      busy    = 1'b0;
      rmac_en = 1'b0;
      done    = 1'b0;
      case (state_reg)
         ST_IDLE:    ;
         ST_SELECT:  begin busy = 1'b1; rmac_en = 1'b1; end
         ST_SETTLE:  begin busy = 1'b1; rmac_en = 1'b1; end
         ST_DONE:    begin busy = 1'b1; done = 1'b1; end
         default:    busy = 1'b1;
      endcase
   end

   // Selection and results persist in IDLE; an abort freezes them as they are.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_reg       <= '0;
         col_reg       <= '0;
         fault_map_reg <= '0;
         fault_cnt_reg <= '0;
      end else if (start_accept) begin
         row_reg       <= '0;
         col_reg       <= '0;
         fault_map_reg <= '0;
         fault_cnt_reg <= '0;
      end else if (!abort) begin
         if (state_reg == ST_COMPARE && mismatch) begin
            fault_map_reg <= fault_map_reg | sel_hit;
            if (fault_cnt_reg != CNT_W'(NUM_PE))
               fault_cnt_reg <= fault_cnt_reg + CNT_W'(1);
         end
         if (state_reg == ST_ADVANCE && !last_pe) begin
            if (col_reg == COL_W'(COLS - 1)) begin
               col_reg <= '0;
               row_reg <= row_reg + ROW_W'(1);
            end else begin
               col_reg <= col_reg + COL_W'(1);
            end
         end
      end
   end

   assign pe_sel_row = row_reg;
   assign pe_sel_col = col_reg;
   assign fault_map  = fault_map_reg;
   assign fault_cnt  = fault_cnt_reg;
   assign any_fault  = |fault_map_reg;

endmodule
